// File: rtl/fg_pkg.sv
`default_nettype none
// ============================================================
// fg_pkg : shared encodings for the function-generator control
// Rev 1.0
// ============================================================
package fg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_MUTE = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_DIV  = 2'd1;
  localparam logic [1:0] ADDR_DUTY = 2'd2;
  localparam logic [1:0] ADDR_RSVD = 2'd3;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_SEL_LSB = 1;

  localparam logic [7:0] DAC_MID_DEFAULT = 8'h80;

  function automatic logic [7:0] pick_sample(input logic [31:0] src, input logic [1:0] sel);
    return src[{sel, 3'b000} +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================
// tick_gen : reloadable down-counter, one tick per reload+1 cycles
// Rev 1.0
// ============================================================
module tick_gen #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] reload_i,
  output logic             tick_o
);

  logic [WIDTH-1:0] cnt_q;

  // Held at zero while disabled so the first enabled cycle ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!en_i) begin
      cnt_q <= '0;
    end else if (cnt_q == '0) begin
      cnt_q <= reload_i;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick_o = en_i && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/wavegen_ctrl.sv
`default_nettype none
// ============================================================
// wavegen_ctrl : shadowed config, tick-aligned commit, DAC mux/mute
// Rev 1.0
// ============================================================
module wavegen_ctrl
  import fg_pkg::*;
#(
  parameter int unsigned DUTY_CYCLE_BITS = 9,
  parameter int unsigned MUTE_TICKS      = 2,
  parameter logic [7:0]  DAC_MID         = DAC_MID_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_wr_i,
  input  logic [1:0]                 cfg_addr_i,
  input  logic [31:0]                cfg_wdata_i,
  output logic                       cfg_ready_o,
  output logic                       cfg_drop_o,
  input  logic [31:0]                src_data_i,
  output logic                       sample_tick_o,
  output logic [1:0]                 wave_sel_o,
  output logic [DUTY_CYCLE_BITS-1:0] duty_cycle_o,
  output logic [7:0]                 dac_out_o,
  output logic [1:0]                 state_o
);

  localparam logic [3:0] MUTE_LOAD = 4'(MUTE_TICKS);

  logic                       sh_en_q,  act_en_q;
  logic [1:0]                 sh_sel_q, act_sel_q;
  logic [31:0]                sh_div_q, act_div_q;
  logic [DUTY_CYCLE_BITS-1:0] sh_duty_q, act_duty_q;
  logic                       pending_q, drop_q;
  state_e                     state_q;
  logic [3:0]                 mute_q;
  logic [7:0]                 dac_q;

  logic tick, tick_en, commit, wr_ok, sel_change;

  assign tick_en    = (state_q != ST_IDLE);
  assign commit     = pending_q && ((state_q == ST_IDLE) || tick);
  assign wr_ok      = cfg_wr_i && !pending_q;
  assign sel_change = (sh_sel_q != act_sel_q);

  tick_gen #(.WIDTH(32)) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (tick_en),
    .reload_i (act_div_q),
    .tick_o   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_en_q    <= 1'b0;
      sh_sel_q   <= '0;
      sh_div_q   <= '0;
      sh_duty_q  <= '0;
      act_en_q   <= 1'b0;
      act_sel_q  <= '0;
      act_div_q  <= '0;
      act_duty_q <= '0;
      pending_q  <= 1'b0;
      drop_q     <= 1'b0;
      state_q    <= ST_IDLE;
      mute_q     <= '0;
      dac_q      <= DAC_MID;
    end else begin
      drop_q <= cfg_wr_i && pending_q;

      if (wr_ok) begin
        case (cfg_addr_i)
          ADDR_CTRL: begin
            sh_en_q  <= cfg_wdata_i[CTRL_EN_BIT];
            sh_sel_q <= cfg_wdata_i[CTRL_SEL_LSB +: 2];
          end
          ADDR_DIV:  sh_div_q  <= cfg_wdata_i;
          ADDR_DUTY: sh_duty_q <= cfg_wdata_i[DUTY_CYCLE_BITS-1:0];
          default: ;
        endcase
        if (cfg_addr_i != ADDR_RSVD) pending_q <= 1'b1;
      end else if (commit) begin
        pending_q <= 1'b0;
      end

      if (commit) begin
        act_en_q   <= sh_en_q;
        act_sel_q  <= sh_sel_q;
        act_div_q  <= sh_div_q;
        act_duty_q <= sh_duty_q;
      end

      // In RUN/MUTE a commit only happens on a tick, so 'tick' covers commit cycles too.
      case (state_q)
        ST_IDLE: begin
          if (commit && sh_en_q) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (commit && !sh_en_q) begin
            state_q <= ST_IDLE;
            dac_q   <= DAC_MID;
          end else if (commit && sel_change && (MUTE_TICKS != 0)) begin
            state_q <= ST_MUTE;
            mute_q  <= MUTE_LOAD;
            dac_q   <= DAC_MID;
          end else if (tick) begin
            dac_q <= pick_sample(src_data_i, commit ? sh_sel_q : act_sel_q);
          end
        end
        ST_MUTE: begin
          if (commit && !sh_en_q) begin
            state_q <= ST_IDLE;
          end else if (commit && sel_change) begin
            mute_q <= MUTE_LOAD;
          end else if (tick) begin
            mute_q <= mute_q - 1'b1;
            if (mute_q == 4'd1) state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          dac_q   <= DAC_MID;
        end
      endcase
    end
  end

  assign cfg_ready_o   = !pending_q;
  assign cfg_drop_o    = drop_q;
  assign sample_tick_o = tick;
  assign wave_sel_o    = act_sel_q;
  assign duty_cycle_o  = act_duty_q;
  assign dac_out_o     = dac_q;
  assign state_o       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_wavegen_ctrl.sv
`default_nettype none
// ============================================================
// tb_wavegen_ctrl : scoreboard bench for wavegen_ctrl
// Rev 1.0
// ============================================================
module tb_wavegen_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic [31:0] src_data = 32'h44332211;
  logic        cfg_ready, cfg_drop, sample_tick;
  logic [1:0]  wave_sel, state;
  logic [8:0]  duty;
  logic [7:0]  dac;

  int checks = 0;
  int failures = 0;
  logic [9:0] sb_q[$];  // {state, dac}

  always #5 clk = ~clk;

  wavegen_ctrl #(
    .DUTY_CYCLE_BITS (9),
    .MUTE_TICKS      (2),
    .DAC_MID         (8'h80)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_wr_i      (cfg_wr),
    .cfg_addr_i    (cfg_addr),
    .cfg_wdata_i   (cfg_wdata),
    .cfg_ready_o   (cfg_ready),
    .cfg_drop_o    (cfg_drop),
    .src_data_i    (src_data),
    .sample_tick_o (sample_tick),
    .wave_sel_o    (wave_sel),
    .duty_cycle_o  (duty),
    .dac_out_o     (dac),
    .state_o       (state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!cfg_ready && n < 50) begin step(); n++; end
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++; $display("FAIL %s_timeout: cfg_ready=%b required 1", name, cfg_ready);
    end
  endtask

  task automatic wait_tick(input string name);
    int n;
    n = 0;
    while (!sample_tick && n < 50) begin step(); n++; end
    checks++;
    if (sample_tick !== 1'b1) begin
      failures++; $display("FAIL %s_tick_timeout: sample_tick=%b required 1", name, sample_tick);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d required 0", state); end
    checks++; if (dac !== 8'h80) begin failures++; $display("FAIL reset_dac: got %h required 80", dac); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b required 1", cfg_ready); end
    checks++; if (sample_tick !== 1'b0) begin failures++; $display("FAIL reset_tick: got %b required 0", sample_tick); end
    checks++; if (cfg_drop !== 1'b0) begin failures++; $display("FAIL reset_drop: got %b required 0", cfg_drop); end
    checks++; if (wave_sel !== 2'd0 || duty !== 9'd0) begin
      failures++; $display("FAIL reset_active: sel=%0d duty=%0d required 0/0", wave_sel, duty);
    end
  endtask

  task automatic test_run();
    int last, nt;
    logic prev, done;
    logic [9:0] e;
    cfg_write(2'd1, 32'd3);
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL div_ready_low: got %b required 0", cfg_ready); end
    step();
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL div_ready_back: got %b required 1", cfg_ready); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL div_stay_idle: got %0d required 0", state); end
    cfg_write(2'd0, 32'd1);
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL ctrl_ready_low: got %b required 0", cfg_ready); end
    step();
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL run_entry: got %0d required 1", state); end
    last = -1; nt = 0; prev = 1'b0; done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (prev) begin
        e = sb_q.pop_front(); prev = 1'b0;
        checks++;
        if (dac !== e[7:0] || state !== e[9:8]) begin
          failures++; $display("FAIL run_sample: dac=%h state=%0d required %h/%0d", dac, state, e[7:0], e[9:8]);
        end
      end
      if (sample_tick) begin
        if (last >= 0) begin
          checks++;
          if (c - last != 4) begin failures++; $display("FAIL run_period: got %0d required 4", c - last); end
        end
        last = c; nt++;
        sb_q.push_back({2'd1, 8'h11});
        prev = 1'b1;
      end
      if (nt >= 4 && !prev) begin done = 1'b1; break; end
      step();
    end
    checks++; if (!done) begin failures++; $display("FAIL run_timeout: ticks=%0d required 4", nt); end
  endtask

  task automatic test_mute();
    logic armed, prev, done;
    logic [9:0] e;
    wait_tick("mute");
    cfg_write(2'd0, 32'd3);
    armed = 1'b0; prev = 1'b0; done = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (prev) begin
        e = sb_q.pop_front(); prev = 1'b0;
        checks++;
        if (dac !== e[7:0] || state !== e[9:8]) begin
          failures++; $display("FAIL mute_seq: dac=%h state=%0d required %h/%0d", dac, state, e[7:0], e[9:8]);
        end
      end
      if (armed && sb_q.size() == 0) begin done = 1'b1; break; end
      if (sample_tick && (armed || !cfg_ready)) begin
        if (!armed) begin
          armed = 1'b1;
          sb_q.push_back({2'd2, 8'h80});
          sb_q.push_back({2'd2, 8'h80});
          sb_q.push_back({2'd1, 8'h80});
          sb_q.push_back({2'd1, 8'h22});
          sb_q.push_back({2'd1, 8'h22});
        end
        prev = 1'b1;
      end
      step();
    end
    checks++; if (!done) begin failures++; $display("FAIL mute_timeout: left=%0d required 0", sb_q.size()); end
    checks++; if (wave_sel !== 2'd1) begin failures++; $display("FAIL mute_sel: got %0d required 1", wave_sel); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] e;
    wait_tick("b2b");
    step();
    cfg_wr = 1'b1; cfg_addr = 2'd2; cfg_wdata = 32'h055;
    step();
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready: got %b required 0", cfg_ready); end
    cfg_wdata = 32'h1AA;
    step();
    cfg_wr = 1'b0;
    checks++; if (cfg_drop !== 1'b1) begin failures++; $display("FAIL b2b_drop_pulse: got %b required 1", cfg_drop); end
    step();
    checks++; if (cfg_drop !== 1'b0) begin failures++; $display("FAIL b2b_drop_clear: got %b required 0", cfg_drop); end
    checks++; if (duty !== 9'd0) begin failures++; $display("FAIL b2b_early_commit: got %h required 000", duty); end
    checks++; if (sample_tick !== 1'b1) begin failures++; $display("FAIL b2b_tick_align: got %b required 1", sample_tick); end
    sb_q.push_back({2'd1, 8'h22});
    step();
    e = sb_q.pop_front();
    checks++; if (duty !== 9'h055) begin failures++; $display("FAIL b2b_shadow: got %h required 055", duty); end
    checks++; if (dac !== e[7:0] || state !== e[9:8]) begin
      failures++; $display("FAIL b2b_same_sel: dac=%h state=%0d required %h/%0d", dac, state, e[7:0], e[9:8]);
    end
    cfg_write(2'd3, 32'hFFFF_FFFF);
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rsvd_pending: got %b required 1", cfg_ready); end
    checks++; if (wave_sel !== 2'd1 || duty !== 9'h055) begin
      failures++; $display("FAIL rsvd_effect: sel=%0d duty=%h required 1/055", wave_sel, duty);
    end
  endtask

  task automatic test_fast();
    int n;
    logic [9:0] e;
    cfg_write(2'd1, 32'd0);
    wait_ready("fast_div");
    cfg_write(2'd0, 32'd5);
    wait_ready("fast_ctrl");
    checks++; if (state !== 2'd2 || wave_sel !== 2'd2) begin
      failures++; $display("FAIL fast_mute_entry: state=%0d sel=%0d required 2/2", state, wave_sel);
    end
    n = 0;
    while (state != 2'd1 && n < 50) begin step(); n++; end
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL fast_run_timeout: got %0d required 1", state); end
    step();
    for (int i = 0; i < 8; i++) sb_q.push_back({2'd1, 8'h33});
    for (int i = 0; i < 8; i++) begin
      e = sb_q.pop_front();
      checks++;
      if (sample_tick !== 1'b1 || dac !== e[7:0]) begin
        failures++; $display("FAIL fast_stream: tick=%b dac=%h required 1/%h", sample_tick, dac, e[7:0]);
      end
      step();
    end
  endtask

  task automatic test_disable();
    cfg_write(2'd0, 32'd0);
    wait_ready("disable");
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL disable_state: got %0d required 0", state); end
    checks++; if (dac !== 8'h80) begin failures++; $display("FAIL disable_dac: got %h required 80", dac); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sample_tick !== 1'b0) begin failures++; $display("FAIL disable_tick: got %b required 0", sample_tick); end
      step();
    end
  endtask

  task automatic test_reset_midrun();
    cfg_write(2'd0, 32'd3);
    wait_ready("rst_run");
    step(); step();
    checks++; if (dac !== 8'h22) begin failures++; $display("FAIL prerst_dac: got %h required 22", dac); end
    cfg_write(2'd1, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dac !== 8'h80) begin failures++; $display("FAIL midrst_dac: got %h required 80", dac); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL midrst_state: got %0d required 0", state); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready: got %b required 1", cfg_ready); end
    checks++; if (sample_tick !== 1'b0) begin failures++; $display("FAIL midrst_tick: got %b required 0", sample_tick); end
    checks++; if (wave_sel !== 2'd0) begin failures++; $display("FAIL midrst_sel: got %0d required 0", wave_sel); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(); step();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL postrst_state: got %0d required 0", state); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_mute();
    test_back_to_back();
    test_fast();
    test_disable();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
